memory_access: RTL and testbench
================================

# memory_access

Memory stage of the five-stage RV64 pipeline. Consumes the mem_t/wri_t registers written by the execute stage, performs at most one data-bus load or store per instruction through a valid/data_ok handshake, and aligns and extends load data. On the pipeline-controller `update` pulse it writes the writeback-stage registers. The block is the receiving end of execute's mem_nxt/mem_fun3/mem_pc interface and the initiating end of the data bus.

## Interface
Parameters: none. Widths come from the common package (data_data_t = 64 b, func_addr_t = 64 b).
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- mem_now  in  mem_t  mem_read, mem_write, write_data, data_addr from execute
- mem_fun3  in  3  funct3 of the access
- mem_pc  in  64  PC of the instruction in this stage
- wri_now  in  wri_t  writeback control/data from execute
- mem_nop  in  1  stage holds a bubble
- update  in  1  controller advance pulse; all stages latch
- dreq_valid  out  1  bus request valid
- dreq_write  out  1  1 = store
- dreq_addr  out  64  byte address, equal to data_addr
- dreq_strobe  out  8  byte-lane write enables; 0 for loads
- dreq_data  out  64  store data shifted to byte lanes
- dresp_data_ok  in  1  bus completes the request this cycle
- dresp_data  in  64  load data, doubleword-aligned lanes
- finished  out  1  stage result ready; controller may pulse update
- wri_nxt  out  wri_t  writeback-stage register
- wri_pc  out  64  writeback-stage PC register
- wri_nop  out  1  writeback-stage bubble flag

## Operation
- op = !mem_nop && (mem_read || mem_write). off = data_addr[2:0].
- FSM states: IDLE, BUSY, DONE, DRAIN.
  - IDLE: if op and not update, go to BUSY.
  - BUSY: dreq_valid=1 and the request fields are held stable. On data_ok, capture the load result and go to DONE. If update arrives with data_ok, go to IDLE. If update arrives without data_ok, go to DRAIN.
  - DONE: hold until update, then go to IDLE.
  - DRAIN: dreq_valid stays 1. The result is discarded. On data_ok, go to IDLE.
- finished = !op || state==DONE.
- Store size, lane mask before shifting:
  - fun3[1:0] 00 -> 0x01
  - 01 -> 0x03
  - 10 -> 0x0F
  - 11 -> 0xFF
- Store lanes: strobe = (mask << off) truncated to 8 bits. dreq_data = write_data << (8*off).
- An access crossing the doubleword loses the lanes beyond it. Alignment is checked upstream.
- Load result:
  - raw = dresp_data >> (8*off).
  - fun3 000/001/010 sign-extend 8/16/32 bits.
  - 011 takes all 64 bits.
  - 100/101/110 zero-extend 8/16/32 bits.
  - 111 produces 0.
- On update:
  - wri_nop <= mem_nop.
  - If !mem_nop: wri_pc <= mem_pc and wri_nxt <= wri_now.
  - If additionally mem_read and wri_now.st_rd==STRD_MEM_OUT, wri_nxt.write_data <= load result.

## Timing
- Reset values: state=IDLE; dreq_valid=0; wri_nxt=0, wri_pc=0, wri_nop=1; capture register=0.
- dreq_write, dreq_addr, dreq_strobe and dreq_data are driven from mem_now and mem_fun3. They are don't-care while dreq_valid=0.
- Request fields are registered from state. dreq_valid rises one cycle after the op appears in IDLE.
- Minimum load/store latency: op visible in cycle 0, dreq_valid in cycle 1, data_ok in cycle 1, finished=1 in cycle 2.
- A zero-wait bus therefore costs 2 cycles. Each extra wait cycle adds 1.
- Non-memory instructions and bubbles: finished=1 combinationally in cycle 0.
- Request exclusivity:
  - At most one request per instruction. DONE never re-requests.
  - dreq_valid never drops before data_ok.
  - In DRAIN the next instruction waits in IDLE semantics and may not request until drain completes.
- update in IDLE while op is present: the request is not issued. The instruction is treated as flushed.
- Reset mid-BUSY: dreq_valid drops immediately. The bus is reset by the same signal.

## Structure
- Common package additions:
  - mem_state_t enum {MS_IDLE, MS_BUSY, MS_DONE, MS_DRAIN}
  - STRD_MEM_OUT in the state_rd enum
  - funct3 load/store width constants
- One combinational sub-module, load_align (dresp_data, off, fun3 -> 64-bit result). The store lane shift stays inline.

## Test plan
- Zero-wait load: lw, data_addr=0x1004, dresp_data=0x80000001_00000000 with data_ok in the first BUSY cycle -> finished at cycle 2. After update, wri_nxt.write_data=0xFFFFFFFF80000001.
- Store lanes: sh, data_addr=0x2003, write_data=0xBEEF -> dreq_strobe=0x18, dreq_data=0x000000BEEF000000, dreq_write=1, and valid held across 3 wait cycles.
- Unsigned bytes: lbu at off=7, dresp_data=0xF0000000_00000000 -> result 0xF0. The same with lb -> 0xFFFFFFFFFFFFFFF0.
- Bubble and ALU op: mem_nop=1 -> finished=1 with no request; update sets wri_nop=1. An add with no memory access -> finished=1 and wri_nxt=wri_now.
- Flush mid-request: update in BUSY with 2 cycles left to data_ok -> FSM enters DRAIN and dreq_valid stays high until data_ok. The next load's request appears only after data_ok, and wri_nxt is not overwritten by the drained data.
- Async reset during BUSY -> dreq_valid=0 and wri_nop=1 without waiting for a clock edge; the FSM is in IDLE after release.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared types for the RV64 memory stage: bus widths, stage registers,
// memory FSM states, writeback source select and funct3 width codes.
// Ports: none (package).
package memory_access_pkg;

   typedef logic [63:0] data_data_t;
   typedef logic [63:0] func_addr_t;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_BUSY,
      MS_DONE,
      MS_DRAIN
   } mem_state_t;

   // Source of the value written to rd in the writeback stage.
   typedef enum logic [1:0] {
      STRD_NONE,
      STRD_ALU_OUT,
      STRD_MEM_OUT,
      STRD_PC_4
   } state_rd_t;

   // Load funct3 codes; stores use only the low two bits (size).
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      data_data_t write_data;
      func_addr_t data_addr;
   } mem_t;

   typedef struct packed {
      logic       reg_write;
      logic [4:0] rd;
      state_rd_t  st_rd;
      data_data_t write_data;
   } wri_t;

   // Byte-lane enables for an access of the given size, before lane shift.
   function automatic logic [7:0] store_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-bus request/response bundle between the memory stage and memory.
// master = memory stage (drives request, receives data_ok/data);
// slave = memory side. Request fields are valid only while dreq_valid=1.
interface memory_access_if;
   import memory_access_pkg::*;

   logic       dreq_valid;
   logic       dreq_write;
   func_addr_t dreq_addr;
   logic [7:0] dreq_strobe;
   data_data_t dreq_data;
   logic       dresp_data_ok;
   data_data_t dresp_data;

   modport master (
      output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
      input  dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
      output dresp_data_ok, dresp_data
   );
endinterface

// File: rtl/memory_access_load_align.sv
// Load data alignment: shifts the doubleword-aligned bus data down to the
// accessed byte and sign/zero-extends per funct3. Purely combinational.
// Ports: dresp_data (bus lanes), off (addr[2:0]), fun3 -> result (64 b).
module memory_access_load_align
   import memory_access_pkg::*;
(
   input  data_data_t dresp_data,
   input  logic [2:0] off,
   input  logic [2:0] fun3,
   output data_data_t result
);

   data_data_t raw;

   always_comb begin
      raw = dresp_data >> {off, 3'b000};
      case (fun3)
         F3_LB:   result = {{56{raw[7]}},  raw[7:0]};
         F3_LH:   result = {{48{raw[15]}}, raw[15:0]};
         F3_LW:   result = {{32{raw[31]}}, raw[31:0]};
         F3_LD:   result = raw;
         F3_LBU:  result = {56'd0, raw[7:0]};
         F3_LHU:  result = {48'd0, raw[15:0]};
         F3_LWU:  result = {32'd0, raw[31:0]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// Memory stage: one data-bus load/store per instruction, load align, and
// writeback-register update on the controller's update pulse.
// Latency: 2 cycles with a zero-wait bus (+1 per bus wait); non-memory ops
// and bubbles report finished combinationally. Backpressure: dreq_valid is
// held until dresp_data_ok; a request flushed by update is drained (DRAIN)
// before the next instruction may issue.
// Ports: clk, reset (async, active-high); mem_now/mem_fun3/mem_pc/wri_now/
// mem_nop from execute; update from controller; dbus (request master);
// finished to controller; wri_nxt/wri_pc/wri_nop writeback registers.
module memory_access
   import memory_access_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  mem_t                   mem_now,
   input  logic [2:0]             mem_fun3,
   input  func_addr_t             mem_pc,
   input  wri_t                   wri_now,
   input  logic                   mem_nop,
   input  logic                   update,
   memory_access_if.master        dbus,
   output logic                   finished,
   output wri_t                   wri_nxt,
   output func_addr_t             wri_pc,
   output logic                   wri_nop
);

   mem_state_t state, state_nxt;
   logic       op;
   logic [2:0] off;
   logic       issue;
   logic       resp_in_busy;

   logic       req_write;
   func_addr_t req_addr;
   logic [7:0] req_strobe;
   data_data_t req_data;

   data_data_t align_result;
   data_data_t cap_data;
   data_data_t load_result;
   wri_t       wb_data;

   assign op  = !mem_nop && (mem_now.mem_read || mem_now.mem_write);
   assign off = mem_now.data_addr[2:0];

   assign resp_in_busy = (state == MS_BUSY) && dbus.dresp_data_ok;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= MS_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         MS_IDLE: begin
            // update with an op still in IDLE means the op was flushed
            // before it ever reached the bus.
            if (op && !update) begin
               state_nxt = MS_BUSY;
               issue     = 1'b1;
            end
         end
         MS_BUSY: begin
            if (dbus.dresp_data_ok) state_nxt = update ? MS_IDLE : MS_DONE;
            else if (update)        state_nxt = MS_DRAIN;
         end
         MS_DONE: begin
            if (update) state_nxt = MS_IDLE;
         end
         MS_DRAIN: begin
            if (dbus.dresp_data_ok) state_nxt = MS_IDLE;
         end
         default: state_nxt = MS_IDLE;
      endcase
   end

   // ---------------- request fields ----------------
   // Latched at issue so they stay stable through BUSY and DRAIN, even
   // after mem_now has moved on to the next instruction during a drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_write  <= 1'b0;
         req_addr   <= '0;
         req_strobe <= '0;
         req_data   <= '0;
      end else if (issue) begin
         req_write  <= mem_now.mem_write;
         req_addr   <= mem_now.data_addr;
         // Lanes shifted past byte 7 are dropped (doubleword crossing).
         req_strobe <= mem_now.mem_write ? (store_mask(mem_fun3[1:0]) << off) : 8'h00;
         req_data   <= mem_now.write_data << {off, 3'b000};
      end
   end

   assign dbus.dreq_valid  = (state == MS_BUSY) || (state == MS_DRAIN);
   assign dbus.dreq_write  = req_write;
   assign dbus.dreq_addr   = req_addr;
   assign dbus.dreq_strobe = req_strobe;
   assign dbus.dreq_data   = req_data;

   // ---------------- load path ----------------
   memory_access_load_align u_load_align (
      .dresp_data (dbus.dresp_data),
      .off        (off),
      .fun3       (mem_fun3),
      .result     (align_result)
   );

   // Drained responses never reach cap_data: only BUSY captures.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             cap_data <= '0;
      else if (resp_in_busy) cap_data <= align_result;
   end

   // update coinciding with data_ok in BUSY bypasses the capture register.
   assign load_result = resp_in_busy ? align_result : cap_data;

   assign finished = !op || (state == MS_DONE);

   // ---------------- writeback registers ----------------
   always_comb begin
      wb_data = wri_now;
      if (mem_now.mem_read && (wri_now.st_rd == STRD_MEM_OUT))
         wb_data.write_data = load_result;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wri_nxt <= '0;
         wri_pc  <= '0;
         wri_nop <= 1'b1;
      end else if (update) begin
         wri_nop <= mem_nop;
         if (!mem_nop) begin
            wri_pc  <= mem_pc;
            wri_nxt <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed loads/stores, bubbles, flushes and
// async reset. Expected bus requests and writeback register values are
// queued by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_memory_access;
   import memory_access_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   mem_t       mem_now;
   logic [2:0] mem_fun3;
   func_addr_t mem_pc;
   wri_t       wri_now;
   logic       mem_nop;
   logic       update;
   logic       finished;
   wri_t       wri_nxt;
   func_addr_t wri_pc;
   logic       wri_nop;

   memory_access_if bus();

   memory_access dut (
      .clk      (clk),
      .reset    (reset),
      .mem_now  (mem_now),
      .mem_fun3 (mem_fun3),
      .mem_pc   (mem_pc),
      .wri_now  (wri_now),
      .mem_nop  (mem_nop),
      .update   (update),
      .dbus     (bus),
      .finished (finished),
      .wri_nxt  (wri_nxt),
      .wri_pc   (wri_pc),
      .wri_nop  (wri_nop)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       wr;
      logic [63:0] addr;
      logic [7:0] strobe;
      logic [63:0] data;
   } bus_exp_t;

   typedef struct packed {
      logic        nop;
      logic [63:0] pc;
      wri_t        nxt;
   } wb_exp_t;

   bus_exp_t   bus_q[$];
   wb_exp_t    wb_q[$];
   int         errors = 0;
   int         checks = 0;
   func_addr_t model_pc;
   wri_t       model_nxt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Bubbles leave wri_pc/wri_nxt unchanged, so the model only advances
   // on real instructions.
   task automatic expect_wb(input logic nop, input logic [63:0] pc, input wri_t nxt);
      wb_exp_t e;
      if (!nop) begin
         model_pc  = pc;
         model_nxt = nxt;
      end
      e.nop = nop;
      e.pc  = model_pc;
      e.nxt = model_nxt;
      wb_q.push_back(e);
   endtask

   // One memory instruction from IDLE through update, with 'waits' bus
   // wait cycles; exp_wd is the hand-computed load result (if any).
   task automatic run_access(input string tag, input mem_t m, input logic [2:0] f3,
                             input logic [63:0] pc, input wri_t w, input int waits,
                             input logic [63:0] rdata, input logic [7:0] exp_strobe,
                             input logic [63:0] exp_data, input logic [63:0] exp_wd);
      bus_exp_t be;
      wri_t     wexp;
      mem_now = m; mem_fun3 = f3; mem_pc = pc; wri_now = w;
      mem_nop = 1'b0; update = 1'b0; bus.dresp_data_ok = 1'b0;
      #1;
      chk({tag, "_fin_c0"},   finished, 0);
      chk({tag, "_valid_c0"}, bus.dreq_valid, 0);
      be.wr = m.mem_write; be.addr = m.data_addr; be.strobe = exp_strobe; be.data = exp_data;
      bus_q.push_back(be);
      cyc();
      for (int i = 0; i < waits; i++) begin
         chk({tag, "_valid_wait"}, bus.dreq_valid, 1);
         chk({tag, "_addr_wait"},  bus.dreq_addr, m.data_addr);
         chk({tag, "_fin_wait"},   finished, 0);
         cyc();
      end
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = rdata;
      #1 chk({tag, "_valid_ok"}, bus.dreq_valid, 1);
      cyc();
      bus.dresp_data_ok = 1'b0;
      #1 chk({tag, "_fin_done"}, finished, 1);
      wexp = w;
      if (m.mem_read && w.st_rd == STRD_MEM_OUT) wexp.write_data = exp_wd;
      update = 1'b1;
      expect_wb(1'b0, pc, wexp);
      cyc();
      update  = 1'b0;
      mem_nop = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      bus_exp_t be;
      wb_exp_t  we;
      logic     u;
      forever begin
         @(posedge clk);
         u = update && !reset;
         @(negedge clk);
         if (bus.dreq_valid && bus.dresp_data_ok) begin
            checks++;
            if (bus_q.size() == 0) begin
               errors++;
               $display("FAIL bus_unexpected: got request addr %h expected none", bus.dreq_addr);
            end else begin
               be = bus_q.pop_front();
               if ({bus.dreq_write, bus.dreq_addr, bus.dreq_strobe, bus.dreq_data} !== be) begin
                  errors++;
                  $display("FAIL bus_req: got w=%b a=%h s=%h d=%h expected w=%b a=%h s=%h d=%h",
                           bus.dreq_write, bus.dreq_addr, bus.dreq_strobe, bus.dreq_data,
                           be.wr, be.addr, be.strobe, be.data);
               end
            end
         end
         if (u) begin
            checks++;
            if (wb_q.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected: got update with pc %h expected none", wri_pc);
            end else begin
               we = wb_q.pop_front();
               if ({wri_nop, wri_pc, wri_nxt} !== we) begin
                  errors++;
                  $display("FAIL wb_regs: got nop=%b pc=%h nxt=%h expected nop=%b pc=%h nxt=%h",
                           wri_nop, wri_pc, wri_nxt, we.nop, we.pc, we.nxt);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      mem_t m;
      wri_t w;
      reset = 1'b1; update = 1'b0; mem_nop = 1'b1;
      mem_now = '0; mem_fun3 = 3'b000; mem_pc = '0; wri_now = '0;
      bus.dresp_data_ok = 1'b0; bus.dresp_data = '0;
      model_pc = '0; model_nxt = '0;

      #3;
      chk("rst_valid",   bus.dreq_valid, 0);
      chk("rst_wri_nop", wri_nop, 1);
      chk("rst_wri_pc",  wri_pc, 0);
      chk("rst_wri_nxt", wri_nxt, 0);
      chk("rst_fin",     finished, 1);
      cyc(); cyc();
      reset = 1'b0;
      cyc();

      // lw, zero-wait: off 4, sign-extend 0x80000001
      m = '{1'b1, 1'b0, 64'h0, 64'h1004};
      w = '{1'b1, 5'd5, STRD_MEM_OUT, 64'h1234};
      run_access("lw", m, F3_LW, 64'h100, w, 0, 64'h80000001_00000000,
                 8'h00, 64'h0, 64'hFFFFFFFF_80000001);

      // sh at off 3 with 3 wait cycles
      m = '{1'b0, 1'b1, 64'hBEEF, 64'h2003};
      w = '{1'b0, 5'd0, STRD_NONE, 64'h2006};
      run_access("sh", m, 3'b001, 64'h200, w, 3, 64'h0,
                 8'h18, 64'h000000BE_EF000000, 64'h0);

      // sw at off 6 crosses the doubleword: upper lanes are lost
      m = '{1'b0, 1'b1, 64'h11223344, 64'h6006};
      run_access("sw_cross", m, 3'b010, 64'h210, w, 0, 64'h0,
                 8'hC0, 64'h33440000_00000000, 64'h0);

      // lbu / lb at off 7
      m = '{1'b1, 1'b0, 64'h0, 64'h3007};
      w = '{1'b1, 5'd7, STRD_MEM_OUT, 64'h0};
      run_access("lbu", m, F3_LBU, 64'h300, w, 0, 64'hF0000000_00000000,
                 8'h00, 64'h0, 64'h00000000_000000F0);
      run_access("lb", m, F3_LB, 64'h304, w, 1, 64'hF0000000_00000000,
                 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFFF0);

      // lhu at off 2, and funct3 111 loads produce 0
      m = '{1'b1, 1'b0, 64'h0, 64'h8002};
      run_access("lhu", m, F3_LHU, 64'h308, w, 0, 64'h00000000_87650000,
                 8'h00, 64'h0, 64'h00000000_00008765);
      m = '{1'b1, 1'b0, 64'h0, 64'h9000};
      run_access("f3_111", m, 3'b111, 64'h30C, w, 0, 64'hFFFFFFFF_FFFFFFFF,
                 8'h00, 64'h0, 64'h0);

      // bubble carrying a load: no request, wri_nop=1, pc/nxt held
      mem_now = '{1'b1, 1'b0, 64'h0, 64'hA000}; mem_fun3 = F3_LD; mem_pc = 64'h900;
      mem_nop = 1'b1;
      #1 chk("bub_fin", finished, 1);
      chk("bub_valid", bus.dreq_valid, 0);
      update = 1'b1;
      expect_wb(1'b1, 64'h0, '0);
      cyc();
      update = 1'b0;
      #1 chk("bub_valid_after", bus.dreq_valid, 0);

      // ALU op: finished immediately, wri_nxt = wri_now
      mem_now = '{1'b0, 1'b0, 64'h0, 64'h0}; mem_pc = 64'hA00; mem_nop = 1'b0;
      wri_now = '{1'b1, 5'd9, STRD_ALU_OUT, 64'h55};
      #1 chk("alu_fin", finished, 1);
      update = 1'b1;
      expect_wb(1'b0, 64'hA00, wri_now);
      cyc();
      update = 1'b0; mem_nop = 1'b1;

      // load flushed by update while still in IDLE: never requested
      mem_now = '{1'b1, 1'b0, 64'h0, 64'hF000}; mem_fun3 = F3_LD; mem_pc = 64'hA80;
      wri_now = '{1'b1, 5'd3, STRD_ALU_OUT, 64'h66}; mem_nop = 1'b0; update = 1'b1;
      expect_wb(1'b0, 64'hA80, wri_now);
      cyc();
      update = 1'b0; mem_nop = 1'b1;
      #1 chk("idle_flush_valid", bus.dreq_valid, 0);
      cyc();
      chk("idle_flush_valid2", bus.dreq_valid, 0);

      // flush mid-request: update in BUSY, data_ok two cycles later
      mem_now = '{1'b1, 1'b0, 64'h0, 64'h4000}; mem_fun3 = F3_LD; mem_pc = 64'hB00;
      wri_now = '{1'b1, 5'd4, STRD_ALU_OUT, 64'h77}; mem_nop = 1'b0;
      bus_q.push_back('{1'b0, 64'h4000, 8'h00, 64'h0});
      cyc();
      chk("drain_busy_valid", bus.dreq_valid, 1);
      update = 1'b1;
      expect_wb(1'b0, 64'hB00, wri_now);
      cyc();
      update = 1'b0;
      mem_now = '{1'b1, 1'b0, 64'h0, 64'h5008}; mem_fun3 = F3_LW; mem_pc = 64'hC00;
      wri_now = '{1'b1, 5'd6, STRD_MEM_OUT, 64'h0};
      #1 chk("drain_valid", bus.dreq_valid, 1);
      chk("drain_fin", finished, 0);
      cyc();
      bus.dresp_data_ok = 1'b1; bus.dresp_data = 64'hDEADBEEF_DEADBEEF;
      #1 chk("drain_valid_ok", bus.dreq_valid, 1);
      cyc();
      m = '{1'b1, 1'b0, 64'h0, 64'h5008};
      w = '{1'b1, 5'd6, STRD_MEM_OUT, 64'h0};
      run_access("after_drain", m, F3_LW, 64'hC00, w, 0, 64'h11111111_8000007B,
                 8'h00, 64'h0, 64'hFFFFFFFF_8000007B);

      // async reset while BUSY
      mem_now = '{1'b1, 1'b0, 64'h0, 64'hD000}; mem_fun3 = F3_LD; mem_pc = 64'hE00;
      mem_nop = 1'b0;
      cyc();
      chk("arst_busy_valid", bus.dreq_valid, 1);
      #2 reset = 1'b1;
      #1 chk("arst_valid", bus.dreq_valid, 0);
      chk("arst_wri_nop", wri_nop, 1);
      model_pc = '0; model_nxt = '0;
      mem_nop = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      #1 chk("arst_idle_valid", bus.dreq_valid, 0);
      cyc();

      // sd after reset, one wait cycle: full lane mask
      m = '{1'b0, 1'b1, 64'h01234567_89ABCDEF, 64'h7000};
      w = '{1'b0, 5'd0, STRD_NONE, 64'h0};
      run_access("sd", m, F3_LD, 64'hF00, w, 1, 64'h0,
                 8'hFF, 64'h01234567_89ABCDEF, 64'h0);

      cyc(); cyc();
      chk("bus_q_empty", bus_q.size(), 0);
      chk("wb_q_empty",  wb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
